// File: rtl/tcp_tx_seg_engine.sv
// tcp_tx_seg_engine: per-flow TCP transmit segment engine.
// Takes a scheduler request, reads the flow state, sizes the next segment
// by MSS / unsent bytes / peer window, writes back our_seq, emits one packet
// descriptor and returns a flag-clear update to the scheduler.
// Optional build macro: TCP_TX_ZWP_EN enables one-byte zero-window probes.
module tcp_tx_seg_engine #(
  parameter int FLOWID_W = 3,
  parameter int PTR_W    = 16,
  parameter int MSS      = 1460,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_req_val,
  output logic                sched_req_rdy,
  input  logic [FLOWID_W-1:0] sched_req_flowid,
  input  logic                sched_req_rt,
  input  logic                sched_req_ack,
  output logic                state_rd_req_val,
  output logic [FLOWID_W-1:0] state_rd_req_flowid,
  input  logic [PTR_W:0]      rd_tail_ptr,
  input  logic [31:0]         rd_our_seq,
  input  logic [31:0]         rd_acked,
  input  logic [15:0]         rd_their_win,
  input  logic [31:0]         rd_their_ack,
  input  logic [15:0]         rd_our_win,
  output logic                state_wr_val,
  output logic [FLOWID_W-1:0] state_wr_flowid,
  output logic [31:0]         state_wr_seq,
  output logic                pkt_val,
  input  logic                pkt_rdy,
  output logic [FLOWID_W-1:0] pkt_flowid,
  output logic [31:0]         pkt_seq,
  output logic [31:0]         pkt_ack,
  output logic [7:0]          pkt_flags,
  output logic [15:0]         pkt_win,
  output logic [PTR_W-1:0]    pkt_pl_addr,
  output logic [PTR_W:0]      pkt_pl_len,
  output logic                upd_val,
  input  logic                upd_rdy,
  output logic [FLOWID_W-1:0] upd_flowid,
  output logic                upd_clr_rt,
  output logic                upd_clr_ack,
  output logic                upd_clr_data
);

  localparam int PW = PTR_W + 1;
  // RDWAIT lasts RD_LAT-1 cycles; the counter is loaded with one less.
  localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;
  localparam logic [7:0] FLAG_ACK = 8'h10;
  localparam logic [7:0] FLAG_PSH = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE, S_RDREQ, S_RDWAIT, S_CAPT, S_CALC, S_PKT, S_UPD
  } state_t;

  state_t              state;
  logic [2:0]          wait_cnt;
  logic [FLOWID_W-1:0] req_flowid;
  logic                req_rt;
  logic                req_ack;

  // Flow state captured once the read response is valid.
  logic [PW-1:0]       cap_tail;
  logic [31:0]         cap_our_seq;
  logic [31:0]         cap_acked;
  logic [15:0]         cap_their_win;
  logic [31:0]         cap_their_ack;
  logic [15:0]         cap_our_win;

  // Segment sizing results (combinational from the captured state).
  logic [PW-1:0]       start_lo;
  logic [PW-1:0]       unsent;
  logic [PW-1:0]       inflight;
  logic [31:0]         win_ext;
  logic [31:0]         avail;
  logic [31:0]         len_w;
  logic [PW-1:0]       calc_len;
  logic [PW-1:0]       rem;
  logic                probe;
  logic                has_data;
  logic                produce;
  logic                clr_data;

  // Segment sizing: all pointer arithmetic is modulo 2^(PTR_W+1).
  always_comb begin
    start_lo = req_rt ? cap_acked[PW-1:0] : cap_our_seq[PW-1:0];
    unsent   = cap_tail - start_lo;
    inflight = start_lo - cap_acked[PW-1:0];
    win_ext  = {16'd0, cap_their_win};
    if (win_ext > 32'(inflight)) begin
      avail = win_ext - 32'(inflight);
    end else begin
      avail = 32'd0;
    end
    len_w = 32'(MSS);
    if (32'(unsent) < len_w) begin
      len_w = 32'(unsent);
    end
    if (avail < len_w) begin
      len_w = avail;
    end
    probe = 1'b0;
`ifdef TCP_TX_ZWP_EN
    // Closed window with nothing in flight: send a single probe byte.
    if (!req_rt && cap_their_win == 16'd0 && unsent != '0 && inflight == '0) begin
      len_w = 32'd1;
      probe = 1'b1;
    end
`endif
    calc_len = len_w[PW-1:0];
    rem      = unsent - calc_len;
    has_data = (calc_len != '0);
    produce  = req_rt | req_ack | has_data;
    clr_data = (rem == '0) && !probe;
  end

  // Control FSM with all outputs registered; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      wait_cnt            <= 3'd0;
      req_flowid          <= '0;
      req_rt              <= 1'b0;
      req_ack             <= 1'b0;
      cap_tail            <= '0;
      cap_our_seq         <= '0;
      cap_acked           <= '0;
      cap_their_win       <= '0;
      cap_their_ack       <= '0;
      cap_our_win         <= '0;
      sched_req_rdy       <= 1'b1;
      state_rd_req_val    <= 1'b0;
      state_rd_req_flowid <= '0;
      state_wr_val        <= 1'b0;
      state_wr_flowid     <= '0;
      state_wr_seq        <= '0;
      pkt_val             <= 1'b0;
      pkt_flowid          <= '0;
      pkt_seq             <= '0;
      pkt_ack             <= '0;
      pkt_flags           <= '0;
      pkt_win             <= '0;
      pkt_pl_addr         <= '0;
      pkt_pl_len          <= '0;
      upd_val             <= 1'b0;
      upd_flowid          <= '0;
      upd_clr_rt          <= 1'b0;
      upd_clr_ack         <= 1'b0;
      upd_clr_data        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sched_req_val) begin
            req_flowid          <= sched_req_flowid;
            req_rt              <= sched_req_rt;
            req_ack             <= sched_req_ack;
            sched_req_rdy       <= 1'b0;
            state_rd_req_val    <= 1'b1;
            state_rd_req_flowid <= sched_req_flowid;
            state               <= S_RDREQ;
          end
        end
        S_RDREQ: begin
          state_rd_req_val <= 1'b0;
          wait_cnt         <= WAIT_INIT;
          state            <= (RD_LAT > 1) ? S_RDWAIT : S_CAPT;
        end
        S_RDWAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_CAPT: begin
          cap_tail      <= rd_tail_ptr;
          cap_our_seq   <= rd_our_seq;
          cap_acked     <= rd_acked;
          cap_their_win <= rd_their_win;
          cap_their_ack <= rd_their_ack;
          cap_our_win   <= rd_our_win;
          state         <= S_CALC;
        end
        S_CALC: begin
          state_wr_val    <= !req_rt && has_data;
          state_wr_flowid <= req_flowid;
          state_wr_seq    <= cap_our_seq + 32'(calc_len);
          pkt_flowid      <= req_flowid;
          pkt_seq         <= req_rt ? cap_acked : cap_our_seq;
          pkt_ack         <= cap_their_ack;
          pkt_flags       <= FLAG_ACK | (has_data ? FLAG_PSH : 8'h00);
          pkt_win         <= cap_our_win;
          pkt_pl_addr     <= req_rt ? cap_acked[PTR_W-1:0] : cap_our_seq[PTR_W-1:0];
          pkt_pl_len      <= calc_len;
          upd_flowid      <= req_flowid;
          upd_clr_rt      <= req_rt;
          upd_clr_ack     <= 1'b1;
          upd_clr_data    <= clr_data;
          if (produce) begin
            pkt_val <= 1'b1;
            state   <= S_PKT;
          end else begin
            upd_val <= 1'b1;
            state   <= S_UPD;
          end
        end
        S_PKT: begin
          state_wr_val <= 1'b0;
          if (pkt_rdy) begin
            pkt_val <= 1'b0;
            upd_val <= 1'b1;
            state   <= S_UPD;
          end
        end
        S_UPD: begin
          state_wr_val <= 1'b0;
          if (upd_rdy) begin
            upd_val       <= 1'b0;
            sched_req_rdy <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_seg_engine.sv
// Bench for tcp_tx_seg_engine: directed cases followed by randomized flows,
// each checked against an arithmetic segment-sizing model.
module tb_tcp_tx_seg_engine;

  localparam int FLOWID_W = 3;
  localparam int PTR_W    = 16;
  localparam int MSS      = 1460;
  localparam int RD_LAT   = 1;
  localparam longint M    = longint'(1) << (PTR_W + 1);

  logic                clk;
  logic                rst;
  logic                sched_req_val;
  logic                sched_req_rdy;
  logic [FLOWID_W-1:0] sched_req_flowid;
  logic                sched_req_rt;
  logic                sched_req_ack;
  logic                state_rd_req_val;
  logic [FLOWID_W-1:0] state_rd_req_flowid;
  logic [PTR_W:0]      rd_tail_ptr;
  logic [31:0]         rd_our_seq;
  logic [31:0]         rd_acked;
  logic [15:0]         rd_their_win;
  logic [31:0]         rd_their_ack;
  logic [15:0]         rd_our_win;
  logic                state_wr_val;
  logic [FLOWID_W-1:0] state_wr_flowid;
  logic [31:0]         state_wr_seq;
  logic                pkt_val;
  logic                pkt_rdy;
  logic [FLOWID_W-1:0] pkt_flowid;
  logic [31:0]         pkt_seq;
  logic [31:0]         pkt_ack;
  logic [7:0]          pkt_flags;
  logic [15:0]         pkt_win;
  logic [PTR_W-1:0]    pkt_pl_addr;
  logic [PTR_W:0]      pkt_pl_len;
  logic                upd_val;
  logic                upd_rdy;
  logic [FLOWID_W-1:0] upd_flowid;
  logic                upd_clr_rt;
  logic                upd_clr_ack;
  logic                upd_clr_data;

  int checks = 0;
  int errors = 0;

  tcp_tx_seg_engine #(
    .FLOWID_W(FLOWID_W), .PTR_W(PTR_W), .MSS(MSS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .sched_req_val(sched_req_val), .sched_req_rdy(sched_req_rdy),
    .sched_req_flowid(sched_req_flowid), .sched_req_rt(sched_req_rt),
    .sched_req_ack(sched_req_ack),
    .state_rd_req_val(state_rd_req_val), .state_rd_req_flowid(state_rd_req_flowid),
    .rd_tail_ptr(rd_tail_ptr), .rd_our_seq(rd_our_seq), .rd_acked(rd_acked),
    .rd_their_win(rd_their_win), .rd_their_ack(rd_their_ack), .rd_our_win(rd_our_win),
    .state_wr_val(state_wr_val), .state_wr_flowid(state_wr_flowid),
    .state_wr_seq(state_wr_seq),
    .pkt_val(pkt_val), .pkt_rdy(pkt_rdy), .pkt_flowid(pkt_flowid),
    .pkt_seq(pkt_seq), .pkt_ack(pkt_ack), .pkt_flags(pkt_flags), .pkt_win(pkt_win),
    .pkt_pl_addr(pkt_pl_addr), .pkt_pl_len(pkt_pl_len),
    .upd_val(upd_val), .upd_rdy(upd_rdy), .upd_flowid(upd_flowid),
    .upd_clr_rt(upd_clr_rt), .upd_clr_ack(upd_clr_ack), .upd_clr_data(upd_clr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every per-transaction bound.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: segment sizing straight from the TCP rules using integer math.
  task automatic model(input logic rt, input logic ack, input longint tail,
                       input longint our_seq, input longint acked, input longint win,
                       output longint len, output logic produce, output logic wr,
                       output logic [31:0] wr_seq, output logic [31:0] pseq,
                       output logic [7:0] flags, output logic clr_data);
    longint s, unsent, inflight, avail;
    logic probe;
    s        = (rt ? acked : our_seq) % M;
    unsent   = (tail - s + M) % M;
    inflight = (s - (acked % M) + M) % M;
    avail    = (win > inflight) ? win - inflight : 0;
    len      = MSS;
    if (unsent < len) len = unsent;
    if (avail < len) len = avail;
    probe = 1'b0;
`ifdef TCP_TX_ZWP_EN
    if (!rt && win == 0 && unsent != 0 && inflight == 0) begin
      len   = 1;
      probe = 1'b1;
    end
`endif
    produce  = rt || ack || (len != 0);
    wr       = !rt && (len != 0);
    wr_seq   = 32'((our_seq + len) & 64'hFFFF_FFFF);
    pseq     = rt ? 32'(acked) : 32'(our_seq);
    flags    = (len != 0) ? 8'h18 : 8'h10;
    clr_data = !probe && (unsent - len == 0);
  endtask

  task automatic garbage_rd();
    rd_tail_ptr  = 17'($urandom);
    rd_our_seq   = $urandom;
    rd_acked     = $urandom;
    rd_their_win = 16'($urandom);
    rd_their_ack = $urandom;
    rd_our_win   = 16'($urandom);
  endtask

  task automatic run_txn(input string name, input logic [2:0] fid, input logic rt,
                         input logic ack, input logic [16:0] tail,
                         input logic [31:0] our_seq, input logic [31:0] acked,
                         input logic [15:0] twin, input logic [31:0] tack,
                         input logic [15:0] owin, input int pstall, input int ustall);
    longint e_len;
    logic e_produce, e_wr, e_clr;
    logic [31:0] e_wr_seq, e_pseq;
    logic [7:0] e_flags;
    int wr_cnt, pkt_hs, upd_hs, extra_strobe, unstable, busy_rdy, late_val;
    int pleft, uleft;
    logic pkt_seen, upd_seen, done, poke;
    logic [127:0] psnap, usnap;

    model(rt, ack, longint'(tail), longint'(our_seq), longint'(acked), longint'(twin),
          e_len, e_produce, e_wr, e_wr_seq, e_pseq, e_flags, e_clr);
    $display("txn %s fid=%0d rt=%0b ack=%0b tail=0x%0h seq=0x%0h acked=0x%0h win=%0d -> len=%0d produce=%0b wr=%0b clr_data=%0b",
             name, fid, rt, ack, tail, our_seq, acked, twin, e_len, e_produce, e_wr, e_clr);

    @(negedge clk);
    check({name, ".req_rdy"}, 64'(sched_req_rdy), 64'd1);
    sched_req_val    = 1'b1;
    sched_req_flowid = fid;
    sched_req_rt     = rt;
    sched_req_ack    = ack;
    @(negedge clk);
    // A second request is optionally held during the busy period; it must be ignored.
    poke             = 1'($urandom_range(0, 1));
    sched_req_val    = poke;
    sched_req_flowid = 3'($urandom);
    sched_req_rt     = 1'($urandom);
    sched_req_ack    = 1'($urandom);
    check({name, ".rd_strobe"}, 64'(state_rd_req_val), 64'd1);
    check({name, ".rd_flowid"}, 64'(state_rd_req_flowid), 64'(fid));

    wr_cnt = 0; pkt_hs = 0; upd_hs = 0; extra_strobe = 0; unstable = 0;
    busy_rdy = 0; late_val = 0; pleft = pstall; uleft = ustall;
    pkt_seen = 1'b0; upd_seen = 1'b0; done = 1'b0; psnap = '0; usnap = '0;

    fork
      begin
        // Flow-state memory: response valid exactly RD_LAT cycles after the strobe.
        repeat (RD_LAT) @(posedge clk);
        #1;
        rd_tail_ptr  = tail;
        rd_our_seq   = our_seq;
        rd_acked     = acked;
        rd_their_win = twin;
        rd_their_ack = tack;
        rd_our_win   = owin;
        @(posedge clk);
        #1 garbage_rd();
      end
      begin
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
          @(negedge clk);
          if (state_rd_req_val) extra_strobe++;
          if (state_wr_val) begin
            wr_cnt++;
            check({name, ".wr_flowid"}, 64'(state_wr_flowid), 64'(fid));
            check({name, ".wr_seq"}, 64'(state_wr_seq), 64'(e_wr_seq));
          end
          if (pkt_rdy) begin
            pkt_rdy = 1'b0;
            pkt_hs++;
            if (pkt_val) late_val++;
          end else if (pkt_val) begin
            if (!pkt_seen) begin
              pkt_seen = 1'b1;
              psnap = {pkt_flowid, pkt_seq, pkt_ack, pkt_flags, pkt_win, pkt_pl_addr, pkt_pl_len};
              check({name, ".pkt_flowid"}, 64'(pkt_flowid), 64'(fid));
              check({name, ".pkt_seq"}, 64'(pkt_seq), 64'(e_pseq));
              check({name, ".pkt_ack"}, 64'(pkt_ack), 64'(tack));
              check({name, ".pkt_flags"}, 64'(pkt_flags), 64'(e_flags));
              check({name, ".pkt_win"}, 64'(pkt_win), 64'(owin));
              check({name, ".pkt_pl_addr"}, 64'(pkt_pl_addr), 64'(e_pseq[PTR_W-1:0]));
              check({name, ".pkt_pl_len"}, 64'(pkt_pl_len), 64'(e_len));
            end else if (psnap != {pkt_flowid, pkt_seq, pkt_ack, pkt_flags, pkt_win,
                                   pkt_pl_addr, pkt_pl_len}) begin
              unstable++;
            end
            if (pleft == 0) pkt_rdy = 1'b1;
            else pleft--;
          end
          if (upd_rdy) begin
            upd_rdy = 1'b0;
            upd_hs++;
            if (upd_val) late_val++;
            done = 1'b1;
            sched_req_val = 1'b0;
            check({name, ".idle_rdy"}, 64'(sched_req_rdy), 64'd1);
          end else begin
            if (sched_req_rdy) busy_rdy++;
            if (upd_val) begin
              if (!upd_seen) begin
                upd_seen = 1'b1;
                usnap = 128'({upd_flowid, upd_clr_rt, upd_clr_ack, upd_clr_data});
                check({name, ".upd_flowid"}, 64'(upd_flowid), 64'(fid));
                check({name, ".upd_clr_rt"}, 64'(upd_clr_rt), 64'(rt));
                check({name, ".upd_clr_ack"}, 64'(upd_clr_ack), 64'd1);
                check({name, ".upd_clr_data"}, 64'(upd_clr_data), 64'(e_clr));
              end else if (usnap != 128'({upd_flowid, upd_clr_rt, upd_clr_ack, upd_clr_data})) begin
                unstable++;
              end
              if (uleft == 0) upd_rdy = 1'b1;
              else uleft--;
            end
          end
        end
      end
    join
    sched_req_val = 1'b0;
    pkt_rdy = 1'b0;
    upd_rdy = 1'b0;
    check({name, ".done"}, 64'(done), 64'd1);
    check({name, ".wr_count"}, 64'(wr_cnt), 64'(e_wr));
    check({name, ".pkt_count"}, 64'(pkt_hs), 64'(e_produce));
    check({name, ".upd_count"}, 64'(upd_hs), 64'd1);
    check({name, ".extra_strobe"}, 64'(extra_strobe), 64'd0);
    check({name, ".stable"}, 64'(unstable), 64'd0);
    check({name, ".busy_rdy"}, 64'(busy_rdy), 64'd0);
    check({name, ".val_drop"}, 64'(late_val), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".req_rdy"}, 64'(sched_req_rdy), 64'd1);
    check({name, ".rd_val"}, 64'(state_rd_req_val), 64'd0);
    check({name, ".wr_val"}, 64'(state_wr_val), 64'd0);
    check({name, ".pkt_val"}, 64'(pkt_val), 64'd0);
    check({name, ".upd_val"}, 64'(upd_val), 64'd0);
  endtask

  initial begin
    logic [2:0] fid;
    logic rt, ack;
    logic [31:0] seq, acked;
    logic [16:0] tail;
    logic [15:0] win;
    int infl, uns, strobes;

    rst = 1'b1;
    sched_req_val = 1'b0; sched_req_flowid = '0; sched_req_rt = 1'b0; sched_req_ack = 1'b0;
    pkt_rdy = 1'b0; upd_rdy = 1'b0;
    garbage_rd();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset.pkt_seq", 64'(pkt_seq), 64'd0);
    check("reset.pkt_pl_len", 64'(pkt_pl_len), 64'd0);
    check("reset.wr_seq", 64'(state_wr_seq), 64'd0);
    check("reset.upd_clr_ack", 64'(upd_clr_ack), 64'd0);
    rst = 1'b0;

    run_txn("new_data", 3'd1, 1'b0, 1'b0, 17'd3000, 32'd1000, 32'd1000, 16'd8000, 32'd77, 16'd4096, 2, 1);
    run_txn("retx", 3'd2, 1'b1, 1'b0, 17'd2000, 32'd2000, 32'd500, 16'd8000, 32'd5, 16'd100, 0, 0);
    run_txn("pure_ack", 3'd3, 1'b0, 1'b1, 17'd700, 32'd700, 32'd700, 16'd8000, 32'd9, 16'd200, 0, 2);
    run_txn("idle_flow", 3'd4, 1'b0, 1'b0, 17'd900, 32'd900, 32'd900, 16'd8000, 32'd1, 16'd1, 0, 3);
    run_txn("zero_win", 3'd5, 1'b0, 1'b0, 17'd5100, 32'd5000, 32'd5000, 16'd0, 32'd2, 16'd2, 0, 0);
    run_txn("wrap_bp", 3'd6, 1'b0, 1'b0, 17'h00010, 32'h0001FFF0, 32'h0001FFF0, 16'd8000, 32'd3, 16'd3, 5, 2);
    run_txn("mss_limit", 3'd7, 1'b0, 1'b0, 17'd9000, 32'd1000, 32'd1000, 16'd60000, 32'd4, 16'd4, 0, 0);
    run_txn("win_limit", 3'd0, 1'b0, 1'b0, 17'd9000, 32'd1000, 32'd400, 16'd1000, 32'd6, 16'd6, 1, 1);

    // Reset in the middle of a transaction: everything drops, nothing follows.
    @(negedge clk);
    sched_req_val = 1'b1; sched_req_flowid = 3'd2; sched_req_rt = 1'b0; sched_req_ack = 1'b1;
    @(negedge clk);
    sched_req_val = 1'b0;
    check("midrst.strobe", 64'(state_rd_req_val), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst.async");
    @(negedge clk);
    rst = 1'b0;
    pkt_rdy = 1'b1; upd_rdy = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state_rd_req_val || state_wr_val || pkt_val || upd_val) strobes++;
    end
    pkt_rdy = 1'b0; upd_rdy = 1'b0;
    check("midrst.no_strobes", 64'(strobes), 64'd0);
    check("midrst.req_rdy", 64'(sched_req_rdy), 64'd1);

    for (int n = 0; n < 40; n++) begin
      fid  = 3'($urandom);
      rt   = ($urandom_range(0, 3) == 0);
      ack  = 1'($urandom);
      seq  = $urandom;
      infl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4000));
      case ($urandom_range(0, 3))
        0: uns = 0;
        1: uns = 1;
        default: uns = int'($urandom_range(1, 6000));
      endcase
      acked = seq - 32'(infl);
      tail  = 17'(seq + 32'(uns));
      case ($urandom_range(0, 3))
        0: win = 16'd0;
        1: win = 16'($urandom_range(0, 3000));
        default: win = 16'($urandom);
      endcase
      run_txn($sformatf("rand%0d", n), fid, rt, ack, tail, seq, acked, win,
              $urandom, 16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
